// File: rtl/traffic_phase_ctrl.sv
// Round-robin multi-phase signal controller with integrated interval timer, sensor extension and all-red walk phase.
// Moore outputs registered from next-state, so lamps change on the same edge as the state; no backpressure (tick-paced).
module traffic_phase_ctrl #(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 4,
  parameter int T_BASE     = 6,
  parameter int T_EXT      = 3,
  parameter int T_YEL      = 2,
  parameter int T_WALK     = 3
) (
  input  logic                    clk,
  input  logic                    Reset_n,
  input  logic                    tick,
  input  logic [NUM_PHASES-1:0]   Sensor_Sync,
  input  logic                    WR,
  input  logic                    Prog_Sync,
  input  logic [1:0]              Time_Sel,
  input  logic [CNT_W-1:0]        Time_Value,
  output logic [3*NUM_PHASES-1:0] Lights,
  output logic                    Walk,
  output logic                    WR_Reset,
  output logic [1:0]              Phase
);

  localparam logic [1:0] GREEN     = 2'd0;
  localparam logic [1:0] GREEN_EXT = 2'd1;
  localparam logic [1:0] YELLOW    = 2'd2;
  localparam logic [1:0] WALK      = 2'd3;

  localparam logic [1:0] LAST_PHASE = 2'(NUM_PHASES - 1);

  // Counter holds (interval-1); a zero interval behaves as one tick.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [3*NUM_PHASES-1:0] lamps(input logic [1:0] st, input logic [1:0] ph);
    logic [3*NUM_PHASES-1:0] l;
    l = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (st != WALK && ph == 2'(p))
        l[3*p +: 3] = (st == YELLOW) ? 3'b010 : 3'b001;
      else
        l[3*p +: 3] = 3'b100;
    end
    return l;
  endfunction

  logic [1:0]       state, nxt_state;
  logic [1:0]       phase, nxt_phase;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] t_base, t_ext, t_yel, t_walk;
  logic             walk_req;
  logic             enter_walk;
  logic             sensor_hit;
  logic             expire;

  assign expire = tick && (cnt == '0);

  always_comb begin
    sensor_hit = 1'b0;
    for (int p = 0; p < NUM_PHASES; p++)
      if (phase == 2'(p)) sensor_hit = Sensor_Sync[p];
  end

  always_comb begin
    nxt_state  = state;
    nxt_phase  = phase;
    enter_walk = 1'b0;
    nxt_cnt    = (tick && cnt != '0) ? cnt - 1'b1 : cnt;
    if (Prog_Sync) begin
      // Restart uses the freshly written base when the base itself is programmed.
      nxt_state = GREEN;
      nxt_phase = 2'd0;
      nxt_cnt   = load_val((Time_Sel == 2'd0) ? Time_Value : t_base);
    end else if (expire) begin
      case (state)
        GREEN: begin
          if (sensor_hit) begin
            nxt_state = GREEN_EXT;
            nxt_cnt   = load_val(t_ext);
          end else begin
            nxt_state = YELLOW;
            nxt_cnt   = load_val(t_yel);
          end
        end
        GREEN_EXT: begin
          nxt_state = YELLOW;
          nxt_cnt   = load_val(t_yel);
        end
        YELLOW: begin
          if (phase != LAST_PHASE) begin
            nxt_state = GREEN;
            nxt_phase = phase + 2'd1;
            nxt_cnt   = load_val(t_base);
          end else if (walk_req) begin
            nxt_state  = WALK;
            enter_walk = 1'b1;
            nxt_cnt    = load_val(t_walk);
          end else begin
            nxt_state = GREEN;
            nxt_phase = 2'd0;
            nxt_cnt   = load_val(t_base);
          end
        end
        default: begin
          nxt_state = GREEN;
          nxt_phase = 2'd0;
          nxt_cnt   = load_val(t_base);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= GREEN;
      phase    <= 2'd0;
      cnt      <= load_val(CNT_W'(T_BASE));
      t_base   <= CNT_W'(T_BASE);
      t_ext    <= CNT_W'(T_EXT);
      t_yel    <= CNT_W'(T_YEL);
      t_walk   <= CNT_W'(T_WALK);
      walk_req <= 1'b0;
      Lights   <= lamps(GREEN, 2'd0);
      Walk     <= 1'b0;
      WR_Reset <= 1'b0;
      Phase    <= 2'd0;
    end else begin
      state <= nxt_state;
      phase <= nxt_phase;
      cnt   <= nxt_cnt;
      if (Prog_Sync) begin
        case (Time_Sel)
          2'd0:    t_base <= Time_Value;
          2'd1:    t_ext  <= Time_Value;
          2'd2:    t_yel  <= Time_Value;
          default: t_walk <= Time_Value;
        endcase
      end
      // Clearing on WALK entry wins over a coincident request.
      if (enter_walk)
        walk_req <= 1'b0;
      else if (WR)
        walk_req <= 1'b1;
      Lights   <= lamps(nxt_state, nxt_phase);
      Walk     <= (nxt_state == WALK);
      WR_Reset <= enter_walk;
      Phase    <= nxt_phase;
    end
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised multi-phase traffic-light controller for NUM_PHASES approaches (2..4).
- Successor to the two-road main/side controller:
  - integrates the interval timer, so no external start_timer/expired pair is needed;
  - one vehicle sensor per phase, each granting a green extension;
  - latched pedestrian walk request, served as an all-red walk phase;
  - run-time programmable interval registers.
- Sits between the synchronisers/debouncers and the lamp drivers.

Parameters:
- NUM_PHASES, 2, number of signal phases served round-robin (legal 2..4)
- CNT_W, 4, width of interval registers and timer counter
- T_BASE, 6, default base green, in ticks
- T_EXT, 3, default sensor green extension, in ticks
- T_YEL, 2, default yellow, in ticks
- T_WALK, 3, default all-red walk interval, in ticks

Ports:
- clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle timebase enable (1 Hz strobe in system)
- Sensor_Sync  in  NUM_PHASES  synchronised vehicle sensor, bit p = phase p
- WR  in  1  synchronised walk-request pulse/level
- Prog_Sync  in  1  synchronised program strobe
- Time_Sel  in  2  interval select: 0 base, 1 ext, 2 yellow, 3 walk
- Time_Value  in  CNT_W  interval value written on Prog_Sync
- Lights  out  3*NUM_PHASES  per-phase lamps, bits [3p+2:3p] = {R,Y,G}
- Walk  out  1  pedestrian walk lamp
- WR_Reset  out  1  one-cycle pulse clearing the external walk-request latch
- Phase  out  2  index of the phase currently owning right-of-way

Behaviour:
- All outputs are registered (Moore). Lights, Walk and Phase are derived from the next-state value, so they change on the same edge as the state.
- Reset (async, Reset_n=0) sets:
  - state GREEN, Phase=0, timer loaded with T_BASE-1;
  - interval registers to parameter defaults; walk latch=0;
  - Lights = phase 0 at 3'b001, all others at 3'b100; Walk=0; WR_Reset=0.
- States: GREEN, GREEN_EXT, YELLOW, WALK.
- Timer:
  - On every state entry the counter loads (interval-1); a programmed value of 0 is treated as 1.
  - The counter decrements only on cycles with tick=1.
  - Expiry = (counter==0 && tick); the transition occurs on that edge.
  - Timer duration is exactly N ticks.
- Transitions:
  - GREEN(p) on expiry: Sensor_Sync[p]=1 sampled on the expiry cycle -> GREEN_EXT(p); else -> YELLOW(p).
  - GREEN_EXT(p) on expiry -> YELLOW(p). There is only one extension per green; the sensor is not re-checked.
  - YELLOW(p) on expiry:
    - p<NUM_PHASES-1 -> GREEN(p+1);
    - p=NUM_PHASES-1 and walk latch=1 -> WALK;
    - otherwise wrap to GREEN(0).
  - WALK on expiry -> GREEN(0).
- Lamps:
  - Active phase shows 001 in GREEN/GREEN_EXT and 010 in YELLOW.
  - Every non-active phase shows 100.
  - In WALK all phases show 100 and Walk=1; Walk=0 in every other state.
- Walk latch:
  - Set by WR=1 in any state, including WALK (the request is then served next round).
  - Cleared on the edge entering WALK. On that same edge clear has priority over a simultaneous WR.
  - WR_Reset=1 for exactly the one cycle following WALK entry.
- Programming:
  - Prog_Sync=1 writes Time_Value into the register selected by Time_Sel.
  - On the same edge the controller restarts at GREEN(0) with the timer reloaded; the walk latch is kept.
  - If Time_Sel=0, the restart uses the newly written base value.
  - Prog_Sync has priority over any expiry in the same cycle.
- Phase is held at the last phase index during WALK.
- Reset mid-interval aborts immediately to the reset state. Programmed intervals are lost on reset.

Test Plan:
All scenarios use NUM_PHASES=3 and defaults unless stated.
1. Round-robin: tick=1 every cycle, no sensors, WR=0 after reset -> phase 0 green 6 cycles, yellow 2, then phase 1 and phase 2 likewise. Lights go 100_100_001 -> 100_100_010 -> 100_001_100; back to phase 0 after 24 cycles; Walk never 1.
2. Sensor extension: Sensor_Sync=3'b010 held -> phase 1 green lasts 9 cycles (6+3); phases 0 and 2 stay at 6. Sensor dropped during GREEN_EXT still completes all 3 ticks.
3. Walk: one-cycle WR pulse during phase 0 -> after phase 2 yellow, WALK for 3 cycles with Lights=100_100_100 and Walk=1; WR_Reset high for exactly the one cycle after WALK entry; next round has no WALK. Also: WR held high across WALK entry -> latch cleared on entry, re-set the next cycle, WALK repeats the following round.
4. Program: Prog_Sync with Time_Sel=2, Time_Value=5 during phase 1 green -> immediate restart to phase 0 green; yellows now last 5 ticks. Time_Value=0 for base -> 1-tick green.
5. Tick gating: tick asserted every 4th cycle -> phase 0 green lasts 24 clk cycles; Lights hold between ticks.
6. Async reset: Reset_n pulled low mid-YELLOW between clock edges -> outputs return to reset values before the next edge; a previously programmed yellow=5 reverts to 2.
